// File: rtl/seg7_scan_decoder_if.sv
// Frame hand-off bus between the 7-segment scan decoder and its consumer.
interface seg7_scan_decoder_if;
  logic        frame_valid_o;
  logic        frame_ready_i;
  logic [31:0] digits_o;
  logic [7:0]  dp_o;
  logic [7:0]  err_o;

  modport master (
    output frame_valid_o,
    output digits_o,
    output dp_o,
    output err_o,
    input  frame_ready_i
  );

  modport slave (
    input  frame_valid_o,
    input  digits_o,
    input  dp_o,
    input  err_o,
    output frame_ready_i
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a scanned active-low 7-segment display, decodes each stable digit
// back to a hex nibble and hands off complete 8-digit frames over valid/ready.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter logic [7:0]  DIGIT_MASK  = 8'hFF,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [7:0]                  disp_seg_i,
  input  logic [7:0]                  disp_an_i,
  seg7_scan_decoder_if.master         frm,
  output logic                        overflow_o,
  output logic                        stall_o
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYC);
  localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  logic [7:0]       an_m, an_s, seg_m, seg_s;
  logic [7:0]       an_prev, seg_prev;
  logic [7:0]       stab_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      work_dig;
  logic [7:0]       work_dp, work_err, seen;
  logic             load_q;

  logic [7:0]       an_inv, seen_upd;
  logic             an_valid, changed, capture, complete, dec_ok;
  logic [2:0]       idx;
  logic [3:0]       nib;

  // Two-flop synchronisers; the previous sample is kept for change detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an_m     <= 8'hFF;
      an_s     <= 8'hFF;
      seg_m    <= 8'hFF;
      seg_s    <= 8'hFF;
      an_prev  <= 8'hFF;
      seg_prev <= 8'hFF;
    end else begin
      an_m     <= disp_an_i;
      an_s     <= an_m;
      seg_m    <= disp_seg_i;
      seg_s    <= seg_m;
      an_prev  <= an_s;
      seg_prev <= seg_s;
    end
  end

  // Anode qualification, dwell tracking and the capture strobe.
  always_comb begin
    an_inv   = ~an_s;
    an_valid = (an_inv != 8'd0) && ((an_inv & (an_inv - 8'd1)) == 8'd0);
    changed  = {an_s, seg_s} != {an_prev, seg_prev};
    capture  = an_valid && !changed && (stab_cnt == STAB_LAST);
    idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_s[i]) idx = 3'(i);
    end
    seen_upd = seen | (8'd1 << idx);
    complete = capture && ((seen_upd & DIGIT_MASK) == DIGIT_MASK);
  end

  // Segment pattern to nibble; unknown patterns flag an error and decode as 0.
  always_comb begin
    nib    = 4'h0;
    dec_ok = 1'b1;
    case (seg_s[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Stability counter: restarts on any change or invalid anode, saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stab_cnt <= 8'd0;
    end else if (changed || !an_valid) begin
      stab_cnt <= 8'd0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Working frame registers and the set of digits seen in this frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      work_dig <= 32'd0;
      work_dp  <= 8'd0;
      work_err <= 8'd0;
      seen     <= 8'd0;
      load_q   <= 1'b0;
    end else begin
      load_q <= complete;
      if (capture) begin
        work_dig[{idx, 2'b00} +: 4] <= nib;
        work_dp[idx]                <= ~seg_s[7];
        work_err[idx]               <= ~dec_ok;
        seen                        <= complete ? 8'd0 : seen_upd;
      end
    end
  end

  // Output frame copy and valid/ready handshake with sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frm.frame_valid_o <= 1'b0;
      frm.digits_o      <= 32'd0;
      frm.dp_o          <= 8'd0;
      frm.err_o         <= 8'd0;
      overflow_o        <= 1'b0;
    end else if (load_q) begin
      frm.frame_valid_o <= 1'b1;
      frm.digits_o      <= work_dig;
      frm.dp_o          <= work_dp;
      frm.err_o         <= work_err;
      if (frm.frame_valid_o && !frm.frame_ready_i) overflow_o <= 1'b1;
    end else if (frm.frame_ready_i) begin
      frm.frame_valid_o <= 1'b0;
    end
  end

  // Capture watchdog: saturating count since the last capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
      stall_o <= 1'b0;
    end else if (capture) begin
      tmo_cnt <= '0;
      stall_o <= 1'b0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      stall_o <= (tmo_cnt + TMO_W'(1)) == TMO_MAX;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: drives scanned display patterns and
// compares every accepted frame against the expected frame queue.
module tb_seg7_scan_decoder;

  localparam int unsigned STAB = 4;
  localparam int unsigned TMO  = 64;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  err;
  } frame_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] seg;
  logic [7:0] an;
  logic       ovf;
  logic       stall;

  seg7_scan_decoder_if frm_if ();

  seg7_scan_decoder #(
    .STABLE_CYC (STAB),
    .DIGIT_MASK (8'hFF),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .disp_seg_i(seg),
    .disp_an_i (an),
    .frm       (frm_if.master),
    .overflow_o(ovf),
    .stall_o   (stall)
  );

  always #5 clk = ~clk;

  frame_t exp_q[$];
  frame_t mon_e;
  int     n_vec = 0;
  int     n_bad = 0;
  int     n_acc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
      4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
      4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
      4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
    endcase
    return {~dp, p};
  endfunction

  function automatic logic [63:0] make_segs(input logic [31:0] nibs, input logic [7:0] dpm);
    logic [63:0] s;
    for (int i = 0; i < 8; i++) s[8*i +: 8] = seg_of(nibs[4*i +: 4], dpm[i]);
    return s;
  endfunction

  function automatic frame_t mk(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    frame_t f;
    f.dig = d;
    f.dp  = p;
    f.err = e;
    return f;
  endfunction

  // Scoreboard: every accepted frame is popped and compared.
  always @(negedge clk) begin
    if (rstn && frm_if.frame_valid_o && frm_if.frame_ready_i) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(frm_if.digits_o), 32'hxxxx_xxxx);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_digits", frm_if.digits_o, mon_e.dig);
        check("frame_dp", 32'(frm_if.dp_o), 32'(mon_e.dp));
        check("frame_err", 32'(frm_if.err_o), 32'(mon_e.err));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    cycles(n);
  endtask

  task automatic scan(input logic [63:0] segs, input int dwell, input bit noisy,
                      input int first, input int last);
    for (int i = first; i <= last; i++) begin
      hold(~(8'd1 << i), segs[8*i +: 8], dwell);
      if (noisy) begin
        hold(8'hFC, segs[8*i +: 8], 16);
        hold(8'hFF, 8'h00, 3);
      end
    end
    hold(8'hFF, 8'hFF, 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      cycles(1);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, 32'(frm_if.frame_valid_o), 32'd0);
    check({pfx, "_digits"}, frm_if.digits_o, 32'd0);
    check({pfx, "_dp"}, 32'(frm_if.dp_o), 32'd0);
    check({pfx, "_err"}, 32'(frm_if.err_o), 32'd0);
    check({pfx, "_ovf"}, 32'(ovf), 32'd0);
    check({pfx, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] s;
    rstn = 1'b0;
    an   = 8'hFF;
    seg  = 8'hFF;
    frm_if.frame_ready_i = 1'b1;
    cycles(3);
    check_zero("reset");
    rstn = 1'b1;
    cycles(2);

    // Clean scan of "12345678".
    exp_q.push_back(mk(32'h87654321, 8'h00, 8'h00));
    scan(make_segs(32'h87654321, 8'h00), 16, 1'b0, 0, 7);
    wait_drain("t1_drain", 50);
    check("t1_acc", 32'(n_acc), 32'd1);
    check("t1_stall", 32'(stall), 32'd0);
    cycles(3);
    check("t1_valid_pulse", 32'(frm_if.frame_valid_o), 32'd0);

    // Short dwells never capture; the watchdog fires, then a real scan clears it.
    repeat (3) scan(make_segs(32'h13579BDF, 8'h00), 3, 1'b0, 0, 7);
    check("t2_short_acc", 32'(n_acc), 32'd1);
    check("t2_short_valid", 32'(frm_if.frame_valid_o), 32'd0);
    check("t2_stall_set", 32'(stall), 32'd1);
    exp_q.push_back(mk(32'h0FEDCBA9, 8'h00, 8'h00));
    scan(make_segs(32'h0FEDCBA9, 8'h00), 16, 1'b0, 0, 7);
    wait_drain("t2_drain", 50);
    check("t2_stall_clear", 32'(stall), 32'd0);

    // Undecodable pattern with dp lit on digit 3, then a clean frame clears err.
    s = make_segs(32'hAAAAAAAA, 8'h00);
    s[31:24] = 8'h7F;
    exp_q.push_back(mk(32'hAAAA0AAA, 8'h08, 8'h08));
    scan(s, 16, 1'b0, 0, 7);
    wait_drain("t3_err_drain", 50);
    exp_q.push_back(mk(32'h55555555, 8'h81, 8'h00));
    scan(make_segs(32'h55555555, 8'h81), 16, 1'b0, 0, 7);
    wait_drain("t3_clean_drain", 50);

    // Back-pressure: second frame overwrites the first and flags overflow.
    frm_if.frame_ready_i = 1'b0;
    scan(make_segs(32'h11111111, 8'h00), 16, 1'b0, 0, 7);
    cycles(5);
    check("t4_first_valid", 32'(frm_if.frame_valid_o), 32'd1);
    check("t4_first_digits", frm_if.digits_o, 32'h11111111);
    check("t4_first_ovf", 32'(ovf), 32'd0);
    scan(make_segs(32'h22222222, 8'h00), 16, 1'b0, 0, 7);
    cycles(5);
    check("t4_second_digits", frm_if.digits_o, 32'h22222222);
    check("t4_second_ovf", 32'(ovf), 32'd1);
    check("t4_second_valid", 32'(frm_if.frame_valid_o), 32'd1);
    exp_q.push_back(mk(32'h22222222, 8'h00, 8'h00));
    frm_if.frame_ready_i = 1'b1;
    cycles(1);
    check("t4_valid_drop", 32'(frm_if.frame_valid_o), 32'd0);
    check("t4_queue", 32'(exp_q.size()), 32'd0);

    // Multi-anode and blank intervals interleaved with a valid scan.
    exp_q.push_back(mk(32'hC0FFEE42, 8'h00, 8'h00));
    scan(make_segs(32'hC0FFEE42, 8'h00), 16, 1'b1, 0, 7);
    wait_drain("t5_drain", 50);

    // Reset after 4 captures discards the partial frame.
    scan(make_segs(32'h99999999, 8'h00), 16, 1'b0, 0, 3);
    rstn = 1'b0;
    cycles(2);
    check_zero("t6_reset");
    rstn = 1'b1;
    cycles(2);
    scan(make_segs(32'h76543210, 8'h00), 16, 1'b0, 4, 7);
    cycles(10);
    check("t6_partial_valid", 32'(frm_if.frame_valid_o), 32'd0);
    exp_q.push_back(mk(32'h76543210, 8'h00, 8'h00));
    scan(make_segs(32'h76543210, 8'h00), 16, 1'b0, 0, 7);
    wait_drain("t6_drain", 50);
    check("total_accepts", 32'(n_acc), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the SoC's multiplexed 7-segment display driver.
- Samples the scanned, active-low anode and segment lines and decodes each lit digit's pattern back into a hex nibble.
- Assembles a full 8-digit frame and hands it off over a valid/ready handshake.
- Used on-chip for display self-check, and as a synthesizable monitor in the SoC bench.

Parameters:
- STABLE_CYC, 4: consecutive identical samples required before a digit is captured (1..255).
- DIGIT_MASK, 8'hFF: digits that must be captured to complete a frame; bit i = anode i.
- TIMEOUT_CYC, 1048576: cycles without any capture before stall_o asserts.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- disp_seg_i  in  8  segments, active-low; [6:0] = {g,f,e,d,c,b,a}, [7] = dp
- disp_an_i  in  8  anodes, active-low; bit i selects digit i
- frame_ready_i  in  1  consumer accepts the frame
- frame_valid_o  out  1  decoded frame available
- digits_o  out  32  nibble i at [4i+3:4i]
- dp_o  out  8  decimal point per digit, active-high
- err_o  out  8  digit i held an undecodable pattern
- overflow_o  out  1  sticky: a frame was dropped
- stall_o  out  1  no capture within TIMEOUT_CYC

Behaviour:
- Reset (async, rstn=0): all outputs 0; internal digit/dp/err/seen registers 0; counters 0; sync flops load 8'hFF (idle/blank).
- Input sync: disp_an_i and disp_seg_i each pass through 2 flops. All decisions use the second stage (an_s, seg_s). Latency from pin to sample is 2 cycles.
- Anode qualification: an_s is valid only when exactly one bit is 0. An all-ones value (blank) or multiple zeros is invalid.
- Stability: an 8-bit counter stab_cnt.
  - Clears whenever {an_s,seg_s} differs from the previous cycle, or an_s is invalid.
  - Otherwise increments, saturating at STABLE_CYC.
- Capture: occurs in the cycle stab_cnt reaches STABLE_CYC with a valid an_s, at index i = position of the zero bit.
  - Only once per dwell. No recapture until {an_s,seg_s} changes.
- Decode table (seg_s[6:0] to nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - Any other pattern: nibble 0 and err bit i = 1. A decodable pattern clears err bit i.
  - dp bit i = ~seg_s[7].
- Frame assembly: each capture writes digit i into the working registers and sets seen[i].
  - When (seen & DIGIT_MASK) == DIGIT_MASK after the update, the frame completes.
  - On completion, the working registers are copied to digits_o, dp_o and err_o in the next cycle. seen clears in the same cycle.
  - Captures on digits outside DIGIT_MASK still update working registers but do not count toward completion.
- Handshake:
  - frame_valid_o rises with the output copy and holds until a cycle with frame_ready_i=1. The output registers are stable while valid and not accepted.
  - If completion and acceptance occur in the same cycle, the new frame loads and valid stays 1.
  - If a frame completes while valid=1 and ready=0, the outputs are overwritten, valid stays 1, and overflow_o sets. overflow_o clears only on reset.
- Stall: a timeout counter resets on every capture.
  - stall_o = 1 when the count reaches TIMEOUT_CYC, with the counter saturating there.
  - The next capture clears stall_o.
- Reset mid-frame: the partial frame is discarded, and the first frame after reset needs all masked digits captured again.

Test Plan:
- Scan 8 digits showing "12345678" (an cycles FE,FD,…,7F; seg 79,24,30,19,12,02,78,00, dp off), 16-cycle dwell, ready=1 → one frame_valid_o pulse with digits_o=32'h87654321, dp_o=0, err_o=0.
- Each dwell of only 3 cycles (< STABLE_CYC+2 sync) → no capture, frame_valid_o stays 0. After TIMEOUT_CYC (set to 64 in the bench) → stall_o=1. A subsequent valid scan clears stall_o.
- Digit 3 driven with seg 7F and dp low (8'h7F on [7:0] with [7]=0) → err_o=8'h08, dp_o=8'h08, nibble 3=0, frame still completes.
- ready=0 for two full scans (first frame 11111111, second 22222222) → digits_o=32'h22222222 after the second, overflow_o=1, valid held. ready=1 for one cycle → valid drops.
- Anode 8'hFC (two digits low) and 8'hFF blanks interleaved with a valid scan → ignored, with frame content identical to the clean scan.
- Assert rstn=0 after 4 digits are captured, then release and scan all 8 → all outputs 0 during reset, and the first frame_valid_o occurs only after all 8 new captures.
